// File: rtl/toy_regfile_wb_arbiter_if.sv
// Writeback request bus and register-file write-port bus.
interface toy_regfile_wb_arbiter_if #(
    parameter int REQ_NUM          = 12,
    parameter int WR_PORT_NUM      = 10,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int REG_WIDTH        = 64
);
    logic [REQ_NUM-1:0]                            req_vld;
    logic [REQ_NUM-1:0]                            req_is_fp;
    logic [REQ_NUM-1:0][PHY_REG_ID_WIDTH-1:0]      req_reg_index;
    logic [REQ_NUM-1:0][REG_WIDTH-1:0]             req_data;
    logic [REQ_NUM-1:0]                            req_rdy;
    logic [WR_PORT_NUM-1:0]                        wr_int_en;
    logic [WR_PORT_NUM-1:0]                        wr_fp_en;
    logic [WR_PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  wr_reg_index;
    logic [WR_PORT_NUM-1:0][REG_WIDTH-1:0]         wr_reg_data;

    modport master (
        output req_vld, req_is_fp, req_reg_index, req_data,
        input  req_rdy, wr_int_en, wr_fp_en, wr_reg_index, wr_reg_data
    );

    modport slave (
        input  req_vld, req_is_fp, req_reg_index, req_data,
        output req_rdy, wr_int_en, wr_fp_en, wr_reg_index, wr_reg_data
    );
endinterface

// File: rtl/toy_regfile_wb_arbiter.sv
// Round-robin writeback arbiter onto register-file write ports; write ports are
// registered one cycle after grant. Ungranted requesters hold and retry; flush blocks all grants.
module toy_regfile_wb_arbiter #(
    parameter int REQ_NUM          = 12,
    parameter int WR_PORT_NUM      = 10,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int REG_WIDTH        = 64,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    toy_regfile_wb_arbiter_if.slave bus,
    output logic [CNT_WIDTH-1:0]    stall_cnt
);
    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PTR_W-1:0]                             rr_ptr;
    logic [PTR_W-1:0]                             last_idx;
    logic [PTR_W-1:0]                             idx;
    logic [REQ_NUM-1:0]                           gnt;
    logic [WR_PORT_NUM-1:0]                       port_vld;
    logic [WR_PORT_NUM-1:0]                       port_fp;
    logic [WR_PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] port_idx;
    logic [WR_PORT_NUM-1:0][REG_WIDTH-1:0]        port_dat;
    logic                                         any_gnt;
    logic                                         conflict;
    logic                                         stall;
    int                                           cnt;
    int                                           pos;

    // Scan from rr_ptr; each grant takes the next free port unless its target is already claimed.
    always_comb begin
        gnt      = '0;
        port_vld = '0;
        port_fp  = '0;
        port_idx = '0;
        port_dat = '0;
        last_idx = rr_ptr;
        any_gnt  = 1'b0;
        conflict = 1'b0;
        idx      = '0;
        cnt      = 0;
        pos      = 0;
        for (int j = 0; j < REQ_NUM; j++) begin
            pos = int'(rr_ptr) + j;
            if (pos >= REQ_NUM) pos = pos - REQ_NUM;
            idx      = PTR_W'(pos);
            conflict = 1'b0;
            for (int p = 0; p < WR_PORT_NUM; p++) begin
                if (port_vld[p] && port_fp[p] == bus.req_is_fp[idx] &&
                    port_idx[p] == bus.req_reg_index[idx])
                    conflict = 1'b1;
            end
            if (!rst && !flush && bus.req_vld[idx] && cnt < WR_PORT_NUM && !conflict) begin
                gnt[idx] = 1'b1;
                for (int p = 0; p < WR_PORT_NUM; p++) begin
                    if (p == cnt) begin
                        port_vld[p] = 1'b1;
                        port_fp[p]  = bus.req_is_fp[idx];
                        port_idx[p] = bus.req_reg_index[idx];
                        port_dat[p] = bus.req_data[idx];
                    end
                end
                cnt      = cnt + 1;
                last_idx = idx;
                any_gnt  = 1'b1;
            end
        end
    end

    assign bus.req_rdy = gnt;
    assign stall       = !flush && |(bus.req_vld & ~gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            bus.wr_int_en    <= '0;
            bus.wr_fp_en     <= '0;
            bus.wr_reg_index <= '0;
            bus.wr_reg_data  <= '0;
            stall_cnt        <= '0;
        end else begin
            if (any_gnt)
                rr_ptr <= (int'(last_idx) == REQ_NUM - 1) ? '0 : last_idx + 1'b1;
            for (int k = 0; k < WR_PORT_NUM; k++) begin
                bus.wr_int_en[k] <= port_vld[k] & ~port_fp[k];
                bus.wr_fp_en[k]  <= port_vld[k] &  port_fp[k];
                if (port_vld[k]) begin
                    bus.wr_reg_index[k] <= port_idx[k];
                    bus.wr_reg_data[k]  <= port_dat[k];
                end
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_toy_regfile_wb_arbiter.sv
// Randomized and directed bench for toy_regfile_wb_arbiter against a queue-based reference model.
module tb_toy_regfile_wb_arbiter;
    localparam int RN = 12;
    localparam int WP = 10;
    localparam int IW = 7;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    toy_regfile_wb_arbiter_if #(.REQ_NUM(RN), .WR_PORT_NUM(WP), .PHY_REG_ID_WIDTH(IW), .REG_WIDTH(DW)) bus ();

    toy_regfile_wb_arbiter #(.REQ_NUM(RN), .WR_PORT_NUM(WP), .PHY_REG_ID_WIDTH(IW),
                             .REG_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int                     n_tests = 0;
    int                     n_fail  = 0;
    int                     m_rr;
    int                     m_stall;
    logic [WP-1:0]          m_int;
    logic [WP-1:0]          m_fp;
    logic [WP-1:0][IW-1:0]  m_idx;
    logic [WP-1:0][DW-1:0]  m_dat;

    // Reference: walk requesters in round-robin order, keep a list of claimed (file,index) targets.
    function automatic void scan(output logic [RN-1:0] g, output int src[WP], output int n);
        int keys[$];
        int r;
        int key;
        bit hit;
        g = '0;
        n = 0;
        for (int k = 0; k < WP; k++) src[k] = 0;
        if (flush) return;
        for (int k = 0; k < RN; k++) begin
            r = (m_rr + k) % RN;
            if (!bus.req_vld[r] || n == WP) continue;
            key = int'(bus.req_is_fp[r]) * 256 + int'(bus.req_reg_index[r]);
            hit = 0;
            foreach (keys[q]) if (keys[q] == key) hit = 1;
            if (hit) continue;
            keys.push_back(key);
            g[r]   = 1'b1;
            src[n] = r;
            n++;
        end
    endfunction

    task automatic tick();
        logic [RN-1:0] g;
        int            src[WP];
        int            n;
        scan(g, src, n);
        @(posedge clk);
        for (int k = 0; k < WP; k++) begin
            if (k < n) begin
                m_int[k] = !bus.req_is_fp[src[k]];
                m_fp[k]  =  bus.req_is_fp[src[k]];
                m_idx[k] =  bus.req_reg_index[src[k]];
                m_dat[k] =  bus.req_data[src[k]];
            end else begin
                m_int[k] = 1'b0;
                m_fp[k]  = 1'b0;
            end
        end
        if (n > 0) m_rr = (src[n-1] + 1) % RN;
        if (!flush && |(bus.req_vld & ~g) && m_stall < 65535) m_stall++;
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        flush             = 1'b0;
        bus.req_vld       = '0;
        bus.req_is_fp     = '0;
        bus.req_reg_index = '0;
        bus.req_data      = '0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_rr    = 0;
        m_stall = 0;
        m_int   = '0;
        m_fp    = '0;
        m_idx   = '0;
        m_dat   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_vld = '1;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h000) begin
            n_fail++; $display("FAIL reset_rdy: got %h want 000", bus.req_rdy);
        end
        n_tests++;
        if (bus.wr_int_en !== '0 || bus.wr_fp_en !== '0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_out: int %h fp %h stall %0d want all 0", bus.wr_int_en, bus.wr_fp_en, stall_cnt);
        end
        n_tests++;
        if (bus.wr_reg_index !== '0 || bus.wr_reg_data !== '0) begin
            n_fail++; $display("FAIL reset_bus: index/data not 0");
        end
        do_reset();
        tick();
        n_tests++;
        if (bus.wr_int_en !== '0 || bus.wr_fp_en !== '0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL idle: int %h fp %h stall %0d want 0", bus.wr_int_en, bus.wr_fp_en, stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < RN; i++) bus.req_reg_index[i] = IW'(i + 1);
        bus.req_vld = '1;
        #1;
        tick();
        bus.req_vld = 12'hC00;
        n_tests++;
        if (bus.wr_int_en !== 10'h3FF) begin
            n_fail++; $display("FAIL mid_burst_en: got %h want 3ff", bus.wr_int_en);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.wr_int_en !== '0 || bus.wr_fp_en !== '0) begin
            n_fail++; $display("FAIL async_rst_en: int %h fp %h want 0", bus.wr_int_en, bus.wr_fp_en);
        end
        do_reset();
        for (int i = 0; i < RN; i++) bus.req_reg_index[i] = IW'(i + 1);
        bus.req_vld = '1;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h3FF || stall_cnt !== '0) begin
            n_fail++; $display("FAIL post_rst: rdy %h stall %0d want 3ff 0", bus.req_rdy, stall_cnt);
        end
        bus.req_vld = '0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_vld[3]       = 1'b1;
        bus.req_is_fp[3]     = 1'b0;
        bus.req_reg_index[3] = 7'h12;
        bus.req_data[3]      = 64'hABCD;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h008) begin
            n_fail++; $display("FAIL single_rdy: got %h want 008", bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        n_tests++;
        if (bus.wr_int_en !== 10'h001 || bus.wr_fp_en !== '0 || bus.wr_reg_index[0] !== 7'h12 ||
            bus.wr_reg_data[0] !== 64'hABCD) begin
            n_fail++; $display("FAIL single_out: int %h fp %h idx %h dat %h want 001 000 12 abcd",
                               bus.wr_int_en, bus.wr_fp_en, bus.wr_reg_index[0], bus.wr_reg_data[0]);
        end
        bus.req_vld[2] = 1'b1; bus.req_reg_index[2] = 7'h01;
        bus.req_vld[5] = 1'b1; bus.req_reg_index[5] = 7'h02;
        #1;
        tick();
        bus.req_vld = '0;
        n_tests++;
        if (bus.wr_reg_index[0] !== 7'h02 || bus.wr_reg_index[1] !== 7'h01 || bus.wr_int_en !== 10'h003) begin
            n_fail++; $display("FAIL rr_after_3: p0 %h p1 %h en %h want 02 01 003",
                               bus.wr_reg_index[0], bus.wr_reg_index[1], bus.wr_int_en);
        end
    endtask

    task automatic test_all12();
        do_reset();
        for (int i = 0; i < RN; i++) begin
            bus.req_reg_index[i] = IW'(8'h20 + i);
            bus.req_data[i]      = DW'(i * 32'h111);
        end
        bus.req_vld = '1;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h3FF) begin
            n_fail++; $display("FAIL all12_rdy: got %h want 3ff", bus.req_rdy);
        end
        tick();
        bus.req_vld = 12'hC00;
        n_tests++;
        if (stall_cnt !== 16'd1 || bus.wr_int_en !== 10'h3FF || bus.wr_reg_index[9] !== 7'h29) begin
            n_fail++; $display("FAIL all12_first: stall %0d en %h p9 %h want 1 3ff 29",
                               stall_cnt, bus.wr_int_en, bus.wr_reg_index[9]);
        end
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'hC00) begin
            n_fail++; $display("FAIL all12_rdy2: got %h want c00", bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        n_tests++;
        if (bus.wr_int_en !== 10'h003 || bus.wr_reg_index[0] !== 7'h2A || bus.wr_reg_index[1] !== 7'h2B ||
            bus.wr_reg_data[1] !== 64'h0BBB || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL all12_second: en %h p0 %h p1 %h stall %0d want 003 2a 2b 1",
                               bus.wr_int_en, bus.wr_reg_index[0], bus.wr_reg_index[1], stall_cnt);
        end
        bus.req_vld = '1;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h3FF) begin
            n_fail++; $display("FAIL all12_wrap: got %h want 3ff", bus.req_rdy);
        end
        bus.req_vld = '0;
    endtask

    task automatic test_conflict();
        do_reset();
        bus.req_vld[2] = 1'b1; bus.req_is_fp[2] = 1'b0; bus.req_reg_index[2] = 7'h40; bus.req_data[2] = 64'h2;
        bus.req_vld[5] = 1'b1; bus.req_is_fp[5] = 1'b0; bus.req_reg_index[5] = 7'h40; bus.req_data[5] = 64'h5;
        bus.req_vld[7] = 1'b1; bus.req_is_fp[7] = 1'b1; bus.req_reg_index[7] = 7'h40; bus.req_data[7] = 64'h7;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h084) begin
            n_fail++; $display("FAIL conflict_rdy: got %h want 084", bus.req_rdy);
        end
        tick();
        bus.req_vld = 12'h020;
        n_tests++;
        if (bus.wr_int_en !== 10'h001 || bus.wr_fp_en !== 10'h002 || bus.wr_reg_data[0] !== 64'h2 ||
            bus.wr_reg_data[1] !== 64'h7 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL conflict_out: int %h fp %h stall %0d want 001 002 1",
                               bus.wr_int_en, bus.wr_fp_en, stall_cnt);
        end
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h020) begin
            n_fail++; $display("FAIL conflict_retry: got %h want 020", bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        n_tests++;
        if (bus.wr_int_en !== 10'h001 || bus.wr_fp_en !== '0 || bus.wr_reg_data[0] !== 64'h5) begin
            n_fail++; $display("FAIL conflict_late: int %h fp %h dat %h want 001 000 5",
                               bus.wr_int_en, bus.wr_fp_en, bus.wr_reg_data[0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.req_vld = 12'h003;
        bus.req_reg_index[0] = 7'h01;
        bus.req_reg_index[1] = 7'h02;
        #1;
        tick();
        for (int i = 4; i < 8; i++) bus.req_reg_index[i] = IW'(8'h50 + i);
        bus.req_vld = 12'h0F0;
        flush = 1'b1;
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h000 || bus.wr_int_en !== 10'h003) begin
            n_fail++; $display("FAIL flush_cycle: rdy %h en %h want 000 003", bus.req_rdy, bus.wr_int_en);
        end
        tick();
        flush = 1'b0;
        n_tests++;
        if (bus.wr_int_en !== '0 || bus.wr_fp_en !== '0 || stall_cnt !== CW'(m_stall)) begin
            n_fail++; $display("FAIL flush_after: en %h fp %h stall %0d want 0 0 %0d",
                               bus.wr_int_en, bus.wr_fp_en, stall_cnt, m_stall);
        end
        #1;
        n_tests++;
        if (bus.req_rdy !== 12'h0F0) begin
            n_fail++; $display("FAIL flush_resume: got %h want 0f0", bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        n_tests++;
        if (bus.wr_int_en !== 10'h00F || bus.wr_reg_index[0] !== 7'h54 || bus.wr_reg_index[3] !== 7'h57) begin
            n_fail++; $display("FAIL flush_grants: en %h p0 %h p3 %h want 00f 54 57",
                               bus.wr_int_en, bus.wr_reg_index[0], bus.wr_reg_index[3]);
        end
    endtask

    task automatic test_random();
        logic [RN-1:0] g;
        int            src[WP];
        int            n;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < RN; r++) begin
                if (!bus.req_vld[r] && $urandom_range(1, 0) == 1) begin
                    bus.req_vld[r]       = 1'b1;
                    bus.req_is_fp[r]     = 1'($urandom_range(1, 0));
                    bus.req_reg_index[r] = IW'($urandom_range(7, 0));
                    bus.req_data[r]      = {$urandom, $urandom};
                end
            end
            flush = ($urandom_range(9, 0) == 0);
            #1;
            scan(g, src, n);
            n_tests++;
            if (bus.req_rdy !== g) begin
                n_fail++; $display("FAIL rand_rdy cyc %0d: got %h want %h", cyc, bus.req_rdy, g);
            end
            tick();
            n_tests++;
            if (bus.wr_int_en !== m_int || bus.wr_fp_en !== m_fp || bus.wr_reg_index !== m_idx ||
                bus.wr_reg_data !== m_dat) begin
                n_fail++; $display("FAIL rand_ports cyc %0d: int %h/%h fp %h/%h (got/want)",
                                   cyc, bus.wr_int_en, m_int, bus.wr_fp_en, m_fp);
            end
            n_tests++;
            if (stall_cnt !== CW'(m_stall)) begin
                n_fail++; $display("FAIL rand_stall cyc %0d: got %0d want %0d", cyc, stall_cnt, m_stall);
            end
            bus.req_vld = bus.req_vld & ~g;
        end
        flush       = 1'b0;
        bus.req_vld = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        bus.req_vld[0] = 1'b1; bus.req_is_fp[0] = 1'b0; bus.req_reg_index[0] = 7'h05;
        bus.req_vld[1] = 1'b1; bus.req_is_fp[1] = 1'b0; bus.req_reg_index[1] = 7'h05;
        #1;
        repeat (100) @(posedge clk);
        #1;
        n_tests++;
        if (stall_cnt !== 16'd100) begin
            n_fail++; $display("FAIL stall_count: got %0d want 100", stall_cnt);
        end
        repeat (65440) @(posedge clk);
        #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_sat: got %0d want 65535", stall_cnt);
        end
        bus.req_vld = '0;
    endtask

    initial begin
        rst               = 1'b1;
        flush             = 1'b0;
        bus.req_vld       = '0;
        bus.req_is_fp     = '0;
        bus.req_reg_index = '0;
        bus.req_data      = '0;
        test_reset();
        test_reset_mid();
        test_single();
        test_all12();
        test_conflict();
        test_flush();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/toy_regfile_wb_arbiter.md
Name: toy_regfile_wb_arbiter

Overview:
- Merges writeback requests from REQ_NUM execution-side sources onto the WR_PORT_NUM int/fp write ports of the physical register file data array.
- Grants requests in round-robin order with a valid/ready handshake and resolves same-register conflicts.
- Drives the register-file write ports from a registered output stage, one cycle after the grant.

Parameters:
- REQ_NUM, 12, number of writeback requesters
- WR_PORT_NUM, 10, number of register-file write ports (equals EU_NUM)
- PHY_REG_ID_WIDTH, 7, physical register index width
- REG_WIDTH, 64, data width
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush
- req_vld  in  REQ_NUM  request valid, one per requester
- req_is_fp  in  REQ_NUM  1 = fp register file, 0 = int register file
- req_reg_index  in  PHY_REG_ID_WIDTH x REQ_NUM  destination physical register
- req_data  in  REG_WIDTH x REQ_NUM  write data
- req_rdy  out  REQ_NUM  grant; the transfer happens when vld&&rdy
- wr_int_en  out  WR_PORT_NUM  int write enable to the register file
- wr_fp_en  out  WR_PORT_NUM  fp write enable to the register file
- wr_reg_index  out  PHY_REG_ID_WIDTH x WR_PORT_NUM  write index
- wr_reg_data  out  REG_WIDTH x WR_PORT_NUM  write data
- stall_cnt  out  CNT_WIDTH  count of cycles with at least one ungranted valid request

Behaviour:
- Reset (asynchronous, active-high):
  - rr_ptr=0.
  - wr_int_en, wr_fp_en, wr_reg_index and wr_reg_data all reset to 0.
  - stall_cnt=0.
  - req_rdy is combinational and is 0 while rst is high.
  - Asserting rst mid-operation drops all write enables immediately; it does not wait for an edge.
- Requester protocol:
  - A requester holds vld, is_fp, index and data stable until it is granted.
  - req_rdy is combinational from req_vld, rr_ptr and flush; ready depends on valid.
  - req_rdy[i]=1 only when req_vld[i]=1.
- Grant scan:
  - Each cycle, requesters are scanned in order rr_ptr, rr_ptr+1, ..., wrapping modulo REQ_NUM.
  - A valid request is granted if both hold:
    - fewer than WR_PORT_NUM grants have been made so far this cycle;
    - no earlier-granted request this cycle has the same (is_fp, reg_index).
  - A same-target loser stays pending and retries next cycle.
  - Int and fp requests to the same index do not conflict.
- Port assignment: the k-th grant in scan order (k=0..WR_PORT_NUM-1) occupies write port k.
- Output stage (registered, latency 1):
  - On the clk edge, port k captures index and data from its grant, and sets wr_int_en[k] = granted && !is_fp and wr_fp_en[k] = granted && is_fp.
  - Unused ports get both enables 0; index and data hold their previous values.
  - Because of the conflict rule, no two enabled ports of the same file ever carry the same index in one cycle.
- rr_ptr update:
  - If there was at least 1 grant: rr_ptr = (index of last granted requester + 1) mod REQ_NUM.
  - Otherwise rr_ptr holds.
  - Requesters skipped only because the port limit was reached are therefore first in line next cycle. Starvation bound: 2 cycles for a conflict-free request.
- Flush:
  - While flush=1, req_rdy is all 0 and no grants are made.
  - On the next edge the output stage enables go to 0 and rr_ptr holds.
  - A write already registered before the flush cycle still retires; it is present on the ports during the flush cycle.
- stall_cnt:
  - Increments by 1 each cycle in which any req_vld&&!req_rdy, flush excluded.
  - Saturates at 2^CNT_WIDTH-1.

Test Plan:
- Reset, then idle; drive rst=1 mid-burst → all wr_*_en=0 immediately; rr_ptr=0 and stall_cnt=0 after release.
- Req 3 vld, int, index 0x12, data 0xABCD → req_rdy[3]=1 the same cycle; next cycle wr_int_en[0]=1, wr_reg_index[0]=0x12, wr_reg_data[0]=0xABCD; rr_ptr=4.
- All 12 requesters valid, distinct indices, rr_ptr=0 → requesters 0-9 granted on ports 0-9; stall_cnt becomes 1; next cycle requesters 10 and 11 granted on ports 0 and 1, rr_ptr=0.
- Req 2 and req 5 both int index 0x40, plus req 7 fp index 0x40, rr_ptr=0 → req 2 and req 7 granted (ports 0 and 1); req 5 granted the following cycle on port 0.
- flush=1 with 4 requests pending and 2 writes already registered → no req_rdy that cycle; the 2 registered writes still appear; enables all 0 the next cycle; grants resume after flush falls.
- Hold one requester valid and ungranted (same-index conflict partner held valid) for 65540 cycles at CNT_WIDTH=16 → stall_cnt saturates at 65535.
